// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns the PC, fetches over a req/gnt/rvalid port, one request in flight.
// Optional FETCH_PERF_EN adds perf_fetched/perf_bubbles counters of IF/ID loads.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrc_E,
    input  logic [31:0] PCTarget_E,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pcplus4_D,
    output logic        valid_D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_pc_f;
    logic [XLEN-1:0]   r_tag;
    logic [XLEN-1:0]   r_buf_instr;
    logic [XLEN-1:0]   r_buf_pc;
    logic              r_buf_valid;
    logic              r_kill;
    logic [XLEN-1:0]   r_instr_d;
    logic [XLEN-1:0]   r_pc_d;
    logic [XLEN-1:0]   r_pcplus4_d;
    logic              r_valid_d;

    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_tag_nxt;
    logic [XLEN-1:0]   w_buf_instr_nxt;
    logic [XLEN-1:0]   w_buf_pc_nxt;
    logic              w_buf_valid_nxt;
    logic              w_kill_nxt;
    logic              w_ifid_ld;
    logic              w_bubble;
    logic [XLEN-1:0]   w_ifid_instr;
    logic [XLEN-1:0]   w_ifid_pc;
    logic [XLEN-1:0]   w_ifid_pc4;
    logic              w_ifid_valid;

    logic              w_req;
    logic              w_grant;
    logic [XLEN-1:0]   w_target;

    // Request is suppressed while in reset so the port is quiet until rst_n releases.
    assign w_req    = rst_n && (r_state == S_IDLE) && !r_buf_valid && !StallF && !PCSrc_E;
    assign w_grant  = w_req && imem_gnt;
    assign w_target = PCTarget_E & ~XLEN'(3);

    assign imem_req  = w_req;
    assign imem_addr = r_pc_f;
    assign instr_D   = r_instr_d;
    assign pc_D      = r_pc_d;
    assign pcplus4_D = r_pcplus4_d;
    assign valid_D   = r_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, PC/buffer updates and IF/ID load selection; redirect overrides everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc_f;
        w_tag_nxt       = r_tag;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_buf_valid_nxt = r_buf_valid;
        w_kill_nxt      = r_kill;
        w_ifid_ld       = 1'b0;
        w_bubble        = 1'b0;
        w_ifid_instr    = r_instr_d;
        w_ifid_pc       = r_pc_d;
        w_ifid_pc4      = r_pcplus4_d;
        w_ifid_valid    = r_valid_d;

        if (PCSrc_E) begin
            w_pc_nxt        = w_target;
            w_buf_valid_nxt = 1'b0;
            w_bubble        = 1'b1;
            case (r_state)
                S_HOLD: w_state_nxt = S_IDLE;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_nxt = S_IDLE;
                        w_kill_nxt  = 1'b0;
                    end else begin
                        w_kill_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        w_pc_nxt    = r_pc_f + XLEN'(4);
                        w_tag_nxt   = r_pc_f;
                        w_state_nxt = S_WAIT;
                    end
                    w_bubble = !StallD;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            w_kill_nxt  = 1'b0;
                            w_state_nxt = S_IDLE;
                            w_bubble    = !StallD;
                        end else if (!StallD) begin
                            w_ifid_ld    = 1'b1;
                            w_ifid_instr = imem_rdata;
                            w_ifid_pc    = r_tag;
                            w_ifid_pc4   = r_tag + XLEN'(4);
                            w_ifid_valid = 1'b1;
                            w_state_nxt  = S_IDLE;
                        end else begin
                            w_buf_instr_nxt = imem_rdata;
                            w_buf_pc_nxt    = r_tag;
                            w_buf_valid_nxt = 1'b1;
                            w_state_nxt     = S_HOLD;
                        end
                    end else begin
                        w_bubble = !StallD;
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        w_ifid_ld       = 1'b1;
                        w_ifid_instr    = r_buf_instr;
                        w_ifid_pc       = r_buf_pc;
                        w_ifid_pc4      = r_buf_pc + XLEN'(4);
                        w_ifid_valid    = 1'b1;
                        w_buf_valid_nxt = 1'b0;
                        w_state_nxt     = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // A bubble keeps pc_D/pcplus4_D and only replaces instruction and valid.
        if (w_bubble) begin
            w_ifid_ld    = 1'b1;
            w_ifid_instr = NOP_INSTR;
            w_ifid_pc    = r_pc_d;
            w_ifid_pc4   = r_pcplus4_d;
            w_ifid_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_f      <= RESET_PC;
            r_tag       <= '0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_buf_valid <= 1'b0;
            r_kill      <= 1'b0;
        end else begin
            r_pc_f      <= w_pc_nxt;
            r_tag       <= w_tag_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_kill      <= w_kill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (w_ifid_ld) begin
            r_instr_d   <= w_ifid_instr;
            r_pc_d      <= w_ifid_pc;
            r_pcplus4_d <= w_ifid_pc4;
            r_valid_d   <= w_ifid_valid;
        end
    end

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] r_perf_fetched;
    logic [XLEN-1:0] r_perf_bubbles;

    // Counts every IF/ID load, split by whether it carried a real instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else if (w_ifid_ld) begin
            if (w_ifid_valid) begin
                r_perf_fetched <= r_perf_fetched + XLEN'(1);
            end else begin
                r_perf_bubbles <= r_perf_bubbles + XLEN'(1);
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`else
    // Performance counters not built.
`endif

endmodule
